// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : program_sequencer
//  Purpose  : Program counter for the serial-clocked core. Advances on
//             qualified step strobes (stepStrobe_i & pcEn_i) with increment,
//             absolute jump, call and return. A return-address stack supports
//             nested calls. The sequential path wraps from LAST_ADDR to
//             WRAP_ADDR.
//  Build    : PC_STACK_EN defined   -> return stack present
//             PC_STACK_EN undefined -> call acts as jump, return acts as
//                                      increment, stack status held constant
//  Ports    : clk_i         system clock, rising edge
//             resetN_i      asynchronous active-low reset
//             stepStrobe_i  one-clk advance pulse
//             pcEn_i        counter enable (qualifies stepStrobe_i)
//             cmd_i         00 inc, 01 jump, 10 call, 11 return
//             target_i      jump/call destination
//             errClr_i      clears sticky stack error
//             memAddr_o     current fetch address
//             wrapPulse_o   one clk after a LAST_ADDR->WRAP_ADDR update
//             stackDepth_o  valid stack entries
//             stackFull_o / stackEmpty_o / stackErr_o  stack status
//  Revision : 1.0  initial release
// ============================================================================
module program_sequencer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int LAST_ADDR   = 2**ADDR_WIDTH - 1,
  parameter int WRAP_ADDR   = 93,
  parameter int RESET_ADDR  = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic                                 clk_i,
  input  logic                                 resetN_i,
  input  logic                                 stepStrobe_i,
  input  logic                                 pcEn_i,
  input  logic [1:0]                           cmd_i,
  input  logic [ADDR_WIDTH-1:0]                target_i,
  input  logic                                 errClr_i,
  output logic [ADDR_WIDTH-1:0]                memAddr_o,
  output logic                                 wrapPulse_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     stackDepth_o,
  output logic                                 stackFull_o,
  output logic                                 stackEmpty_o,
  output logic                                 stackErr_o
);

  localparam logic [ADDR_WIDTH-1:0] c_last_addr  = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] c_wrap_addr  = ADDR_WIDTH'(WRAP_ADDR);
  localparam logic [ADDR_WIDTH-1:0] c_reset_addr = ADDR_WIDTH'(RESET_ADDR);

  localparam logic [1:0] c_cmd_inc  = 2'b00;
  localparam logic [1:0] c_cmd_jump = 2'b01;
  localparam logic [1:0] c_cmd_call = 2'b10;
  localparam logic [1:0] c_cmd_ret  = 2'b11;

  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic                  wrapPulse_q, wrapPulse_d;
  logic                  w_step;
  logic                  w_atLast;
  logic [ADDR_WIDTH-1:0] w_nextSeq;

  assign w_step    = stepStrobe_i & pcEn_i;
  assign w_atLast  = (memAddr_q == c_last_addr);
  // Values above LAST_ADDR never hit the wrap compare and simply roll mod 2**N.
  assign w_nextSeq = w_atLast ? c_wrap_addr : memAddr_q + ADDR_WIDTH'(1);

`ifdef PC_STACK_EN
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  err_q, err_d;
  logic                  w_push;
  logic [IDX_W-1:0]      w_pushIdx;
  logic [IDX_W-1:0]      w_popIdx;

  // Entry index equals current depth for push and depth-1 for pop; the
  // truncation is safe because push is blocked when full and pop when empty.
  assign w_pushIdx = IDX_W'(depth_q);
  assign w_popIdx  = IDX_W'(depth_q - DEPTH_W'(1));
`endif

  always_comb begin
    memAddr_d   = memAddr_q;
    wrapPulse_d = 1'b0;
`ifdef PC_STACK_EN
    depth_d     = depth_q;
    err_d       = err_q;
    w_push      = 1'b0;
    if (errClr_i) err_d = 1'b0;   // a set below overrides the clear
`endif
    if (w_step) begin
      case (cmd_i)
        c_cmd_inc: begin
          memAddr_d   = w_nextSeq;
          wrapPulse_d = w_atLast;
        end
        c_cmd_jump: begin
          memAddr_d = target_i;
        end
        c_cmd_call: begin
`ifdef PC_STACK_EN
          if (!full_q) begin
            w_push    = 1'b1;
            depth_d   = depth_q + DEPTH_W'(1);
            memAddr_d = target_i;
          end else begin
            memAddr_d   = w_nextSeq;
            wrapPulse_d = w_atLast;
            err_d       = 1'b1;
          end
`else
          memAddr_d = target_i;
`endif
        end
        c_cmd_ret: begin
`ifdef PC_STACK_EN
          if (!empty_q) begin
            depth_d   = depth_q - DEPTH_W'(1);
            memAddr_d = stack_q[w_popIdx];
          end else begin
            memAddr_d   = w_nextSeq;
            wrapPulse_d = w_atLast;
            err_d       = 1'b1;
          end
`else
          memAddr_d   = w_nextSeq;
          wrapPulse_d = w_atLast;
`endif
        end
        default: begin
          memAddr_d = memAddr_q;
        end
      endcase
    end
`ifdef PC_STACK_EN
    full_d  = (depth_d == DEPTH_W'(STACK_DEPTH));
    empty_d = (depth_d == '0);
`endif
  end

  always_ff @(posedge clk_i or negedge resetN_i) begin
    if (!resetN_i) begin
      memAddr_q   <= c_reset_addr;
      wrapPulse_q <= 1'b0;
`ifdef PC_STACK_EN
      depth_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      err_q       <= 1'b0;
`endif
    end else begin
      memAddr_q   <= memAddr_d;
      wrapPulse_q <= wrapPulse_d;
`ifdef PC_STACK_EN
      depth_q     <= depth_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      err_q       <= err_d;
`endif
    end
  end

`ifdef PC_STACK_EN
  // Stack contents need no reset: entries are only read below the depth mark.
  always_ff @(posedge clk_i) begin
    if (w_push) stack_q[w_pushIdx] <= w_nextSeq;
  end

  assign stackDepth_o = depth_q;
  assign stackFull_o  = full_q;
  assign stackEmpty_o = empty_q;
  assign stackErr_o   = err_q;
`else
  logic unused_errClr;
  assign unused_errClr = errClr_i;

  assign stackDepth_o = '0;
  assign stackFull_o  = 1'b0;
  assign stackEmpty_o = 1'b1;
  assign stackErr_o   = 1'b0;
`endif

  assign memAddr_o   = memAddr_q;
  assign wrapPulse_o = wrapPulse_q;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_sequencer
//  Purpose  : Directed self-checking bench for program_sequencer
//             (ADDR_WIDTH=8, LAST_ADDR=255, WRAP_ADDR=93, STACK_DEPTH=4).
//             Expected outputs are queued when a step is driven and popped
//             after the sampling edge. Stack scenarios follow PC_STACK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_program_sequencer;

  typedef struct packed {
    logic [7:0] addr;
    logic       wrap;
    logic [2:0] depth;
    logic       err;
  } exp_t;

  logic       clk;
  logic       resetN;
  logic       stepStrobe;
  logic       pcEn;
  logic [1:0] cmd;
  logic [7:0] target;
  logic       errClr;
  logic [7:0] memAddr;
  logic       wrapPulse;
  logic [2:0] stackDepth;
  logic       stackFull;
  logic       stackEmpty;
  logic       stackErr;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  program_sequencer #(
    .ADDR_WIDTH (8),
    .LAST_ADDR  (255),
    .WRAP_ADDR  (93),
    .RESET_ADDR (0),
    .STACK_DEPTH(4)
  ) dut (
    .clk_i        (clk),
    .resetN_i     (resetN),
    .stepStrobe_i (stepStrobe),
    .pcEn_i       (pcEn),
    .cmd_i        (cmd),
    .target_i     (target),
    .errClr_i     (errClr),
    .memAddr_o    (memAddr),
    .wrapPulse_o  (wrapPulse),
    .stackDepth_o (stackDepth),
    .stackFull_o  (stackFull),
    .stackEmpty_o (stackEmpty),
    .stackErr_o   (stackErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] a, input logic w,
                              input logic [2:0] d, input logic e);
    exp_t r;
    r.addr = a; r.wrap = w; r.depth = d; r.err = e;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".memAddr"},    16'(memAddr),    16'(e.addr));
      chk({tag, ".wrapPulse"},  16'(wrapPulse),  16'(e.wrap));
      chk({tag, ".stackDepth"}, 16'(stackDepth), 16'(e.depth));
      chk({tag, ".stackFull"},  16'(stackFull),  16'(e.depth == 3'd4));
      chk({tag, ".stackEmpty"}, 16'(stackEmpty), 16'(e.depth == 3'd0));
      chk({tag, ".stackErr"},   16'(stackErr),   16'(e.err));
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, sample 1 ns after the
  // rising edge that consumes it.
  task automatic step(input string tag, input logic [1:0] c, input logic [7:0] t,
                      input logic en, input logic strb, input logic clr, input exp_t e);
    @(negedge clk);
    stepStrobe = strb;
    pcEn       = en;
    cmd        = c;
    target     = t;
    errClr     = clr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
    stepStrobe = 1'b0;
    errClr     = 1'b0;
  endtask

  // Reset asserted between clock edges; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    resetN = 1'b0;
    sb.push_back(mk(8'd0, 1'b0, 3'd0, 1'b0));
    #1;
    compare_out(tag);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b0; stepStrobe = 1'b0; pcEn = 1'b0;
    cmd = 2'b00; target = 8'd0; errClr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(8'd0, 1'b0, 3'd0, 1'b0));
    compare_out("reset");
    @(negedge clk);
    resetN = 1'b1;

    // Sequential increments then holds
    for (int i = 1; i <= 5; i++)
      step("inc", 2'b00, 8'd0, 1'b1, 1'b1, 1'b0, mk(8'(i), 1'b0, 3'd0, 1'b0));
    step("hold_pcEn0_a", 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, mk(8'd5, 1'b0, 3'd0, 1'b0));
    step("hold_pcEn0_b", 2'b01, 8'd77, 1'b0, 1'b1, 1'b0, mk(8'd5, 1'b0, 3'd0, 1'b0));
    step("hold_nostrb",  2'b00, 8'd0, 1'b1, 1'b0, 1'b0, mk(8'd5, 1'b0, 3'd0, 1'b0));

    // Jump near the end and wrap
    step("jump254",  2'b01, 8'd254, 1'b1, 1'b1, 1'b0, mk(8'd254, 1'b0, 3'd0, 1'b0));
    step("inc255",   2'b00, 8'd0,   1'b1, 1'b1, 1'b0, mk(8'd255, 1'b0, 3'd0, 1'b0));
    step("wrap93",   2'b00, 8'd0,   1'b1, 1'b1, 1'b0, mk(8'd93,  1'b1, 3'd0, 1'b0));
    step("wrapdone", 2'b00, 8'd0,   1'b1, 1'b0, 1'b0, mk(8'd93,  1'b0, 3'd0, 1'b0));

`ifdef PC_STACK_EN
    // Nested call / return
    step("jump10", 2'b01, 8'd10,   1'b1, 1'b1, 1'b0, mk(8'd10,   1'b0, 3'd0, 1'b0));
    step("call40", 2'b10, 8'h40,   1'b1, 1'b1, 1'b0, mk(8'h40,   1'b0, 3'd1, 1'b0));
    step("call80", 2'b10, 8'h80,   1'b1, 1'b1, 1'b0, mk(8'h80,   1'b0, 3'd2, 1'b0));
    step("ret41",  2'b11, 8'd0,    1'b1, 1'b1, 1'b0, mk(8'h41,   1'b0, 3'd1, 1'b0));
    step("ret11",  2'b11, 8'd0,    1'b1, 1'b1, 1'b0, mk(8'd11,   1'b0, 3'd0, 1'b0));

    // Fill, overflow, clear, drain, underflow
    step("jump0", 2'b01, 8'd0, 1'b1, 1'b1, 1'b0, mk(8'd0, 1'b0, 3'd0, 1'b0));
    for (int i = 1; i <= 4; i++)
      step("call20", 2'b10, 8'd20, 1'b1, 1'b1, 1'b0, mk(8'd20, 1'b0, 3'(i), 1'b0));
    step("call_ovf", 2'b10, 8'd20, 1'b1, 1'b1, 1'b0, mk(8'd21, 1'b0, 3'd4, 1'b1));
    step("errclr",   2'b00, 8'd0,  1'b1, 1'b0, 1'b1, mk(8'd21, 1'b0, 3'd4, 1'b0));
    step("ret_a", 2'b11, 8'd0, 1'b1, 1'b1, 1'b0, mk(8'd21, 1'b0, 3'd3, 1'b0));
    step("ret_b", 2'b11, 8'd0, 1'b1, 1'b1, 1'b0, mk(8'd21, 1'b0, 3'd2, 1'b0));
    step("ret_c", 2'b11, 8'd0, 1'b1, 1'b1, 1'b0, mk(8'd21, 1'b0, 3'd1, 1'b0));
    step("ret_d", 2'b11, 8'd0, 1'b1, 1'b1, 1'b0, mk(8'd1,  1'b0, 3'd0, 1'b0));
    step("ret_unf", 2'b11, 8'd0, 1'b1, 1'b1, 1'b0, mk(8'd2, 1'b0, 3'd0, 1'b1));

    // Underflow at LAST_ADDR wraps; error set beats simultaneous clear
    step("jump255",   2'b01, 8'd255, 1'b1, 1'b1, 1'b0, mk(8'd255, 1'b0, 3'd0, 1'b1));
    step("ret_unf_w", 2'b11, 8'd0,   1'b1, 1'b1, 1'b1, mk(8'd93,  1'b1, 3'd0, 1'b1));

    // Three calls deep, then async reset discards stack and error
    step("call30_a", 2'b10, 8'h30, 1'b1, 1'b1, 1'b0, mk(8'h30, 1'b0, 3'd1, 1'b1));
    step("call30_b", 2'b10, 8'h30, 1'b1, 1'b1, 1'b0, mk(8'h30, 1'b0, 3'd2, 1'b1));
    step("call30_c", 2'b10, 8'h30, 1'b1, 1'b1, 1'b0, mk(8'h30, 1'b0, 3'd3, 1'b1));
    async_reset("async_rst");
    step("post_rst_ret", 2'b11, 8'd0, 1'b1, 1'b1, 1'b1, mk(8'd1, 1'b0, 3'd0, 1'b1));
`else
    // Without the stack: call is a jump, return is an increment
    step("jump10",   2'b01, 8'd10,  1'b1, 1'b1, 1'b0, mk(8'd10,  1'b0, 3'd0, 1'b0));
    step("call40",   2'b10, 8'h40,  1'b1, 1'b1, 1'b0, mk(8'h40,  1'b0, 3'd0, 1'b0));
    step("ret41",    2'b11, 8'd0,   1'b1, 1'b1, 1'b0, mk(8'h41,  1'b0, 3'd0, 1'b0));
    step("ret42",    2'b11, 8'd0,   1'b1, 1'b1, 1'b1, mk(8'h42,  1'b0, 3'd0, 1'b0));
    step("jump255",  2'b01, 8'd255, 1'b1, 1'b1, 1'b0, mk(8'd255, 1'b0, 3'd0, 1'b0));
    step("ret_wrap", 2'b11, 8'd0,   1'b1, 1'b1, 1'b0, mk(8'd93,  1'b1, 3'd0, 1'b0));
    step("call_a",   2'b10, 8'h30,  1'b1, 1'b1, 1'b0, mk(8'h30,  1'b0, 3'd0, 1'b0));
    async_reset("async_rst");
    step("post_rst_inc", 2'b00, 8'd0, 1'b1, 1'b1, 1'b0, mk(8'd1, 1'b0, 3'd0, 1'b0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_sequencer.md
# program_sequencer

Parametrised program counter with jump, call/return and configurable wrap window, generating the instruction-memory address for the serial-clocked core. It advances only on qualified step strobes (one per serial byte from the serial clock block), supports absolute jumps and nested subroutine calls through a small return-address stack, and wraps from a configurable last address back to a configurable re-entry address.

## Interface
- ADDR_WIDTH, 16, width of memAddr and all address inputs
- LAST_ADDR, 2**ADDR_WIDTH-1, address after which the counter wraps
- WRAP_ADDR, 93, address loaded when incrementing from LAST_ADDR
- RESET_ADDR, 0, memAddr value in reset
- STACK_DEPTH, 4, return-stack entries (≥1)
- clk  input  1  system clock, all state on rising edge
- resetN  input  1  asynchronous active-low reset
- stepStrobe  input  1  one-clk advance pulse (serial byte boundary)
- pcEn  input  1  counter enable; step ignored when 0
- cmd  input  2  00 increment, 01 jump, 10 call, 11 return
- target  input  ADDR_WIDTH  jump/call destination
- errClr  input  1  clears stackErr
- memAddr  output  ADDR_WIDTH  current fetch address
- wrapPulse  output  1  high one clk after a wrap occurred
- stackDepth  output  $clog2(STACK_DEPTH+1)  valid entries in stack
- stackFull, stackEmpty  output  1  stack status
- stackErr  output  1  sticky overflow/underflow flag

## Operation
- Step = stepStrobe & pcEn. No step: all state holds (errClr still acts).
- nextSeq = (memAddr == LAST_ADDR) ? WRAP_ADDR : memAddr+1 modulo 2**ADDR_WIDTH.
- On step, by cmd:
  - 00: memAddr <= nextSeq.
  - 01: memAddr <= target; stack untouched.
  - 10: if not full, push nextSeq, memAddr <= target; if full, no push, memAddr <= nextSeq, stackErr <= 1.
  - 11: if not empty, memAddr <= popped entry; if empty, memAddr <= nextSeq, stackErr <= 1.
- wrapPulse registered: 1 for exactly one clk after any step whose memAddr update used the LAST_ADDR→WRAP_ADDR path (cmd 00, failed call, failed return); 0 otherwise.
- Stack is LIFO; stackDepth counts 0..STACK_DEPTH; stackFull = (depth==STACK_DEPTH), stackEmpty = (depth==0).
- stackErr: set takes priority over errClr in the same clk.
- target values above LAST_ADDR accepted; increment continues mod 2**ADDR_WIDTH until LAST_ADDR reached.

## Timing
- Reset (resetN low, async): memAddr=RESET_ADDR, stackDepth=0, stackEmpty=1, stackFull=0, stackErr=0, wrapPulse=0; stack contents don't-care. Reset mid-call discards stack.
- Latency: memAddr updates on the rising clk edge that samples step; new value visible that cycle onward; one update per step strobe.
- stepStrobe held high multiple clks = one step per clk (no edge detection inside).
- Status outputs registered, consistent with memAddr in the same cycle.
- Release of resetN synchronised externally; block assumes deassertion meets recovery.

## Configuration
- PC_STACK_EN defined: return stack, stackDepth/Full/Empty/Err as above.
- PC_STACK_EN undefined: no stack storage; cmd 10 behaves as jump (01); cmd 11 behaves as increment (00); stackDepth=0, stackEmpty=1, stackFull=0, stackErr=0 constant; errClr ignored.

## Test plan
(ADDR_WIDTH=8, LAST_ADDR=255, WRAP_ADDR=93, RESET_ADDR=0, STACK_DEPTH=4, PC_STACK_EN defined unless noted)
- Reset then 5 step strobes with cmd 00 -> memAddr 0,1,2,3,4,5; strobes with pcEn=0 -> memAddr holds.
- Jump to 254, two increments -> memAddr 255 then 93; wrapPulse high one clk after the second step only.
- Call 0x40 from 10, call 0x80, return, return -> memAddr 0x40, 0x80, 0x41, 11; stackDepth 1,2,1,0.
- Five calls from 0 to 20 each -> depths 1..4, stackFull after fourth; fifth gives memAddr 21, stackErr=1; errClr -> stackErr 0; return on empty stack -> increment, stackErr=1.
- Assert resetN low asynchronously mid-clock with stackDepth=3 -> memAddr 0, stackDepth 0, stackErr 0 immediately, without a clk edge.
- PC_STACK_EN undefined: call 0x40 from 10 -> memAddr 0x40, stackDepth 0; return -> memAddr 0x41; stackErr stays 0.
